// File: rtl/fides_imcol_serial_if.sv
// Column stream between inverse ShiftRows and the inverse MixColumns unit,
// plus the unit's column-position and framing status.
interface fides_imcol_serial_if #(
    parameter int SHARES = 3,
    parameter int NCOL   = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SHARES*20-1:0]      in_col;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [SHARES*20-1:0]      out_col;
    logic                      out_last;
    logic [$clog2(NCOL)-1:0]   col_idx;
    logic                      err;

    modport slave (
        input  in_valid, in_col, in_last, out_ready,
        output in_ready, out_valid, out_col, out_last, col_idx, err
    );

    modport master (
        output in_valid, in_col, in_last, out_ready,
        input  in_ready, out_valid, out_col, out_last, col_idx, err
    );
endinterface

// File: rtl/fides_imcol_serial.sv
// Column-serial inverse MixColumns for masked Fides-160 decryption: every share
// is mixed by its own disjoint XOR network, then held in a single output register.
module fides_imcol_serial #(
    parameter int SHARES = 3,
    parameter int NCOL   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fides_imcol_serial_if.slave bus
);
    localparam int            CW       = SHARES * 20;
    localparam int            IW       = $clog2(NCOL);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOL - 1);

    // Involutory mix: each output row is the XOR of the other three rows of the
    // same share, i.e. the share's row-parity XOR the row itself.
    function automatic logic [CW-1:0] inv_mix(input logic [CW-1:0] col);
        logic [CW-1:0] res;
        logic [4:0]    par;
        res = '0;
        for (int s = 0; s < SHARES; s++) begin
            par = col[20*s +: 5] ^ col[20*s+5 +: 5] ^ col[20*s+10 +: 5] ^ col[20*s+15 +: 5];
            for (int r = 0; r < 4; r++) begin
                res[20*s+5*r +: 5] = par ^ col[20*s+5*r +: 5];
            end
        end
        return res;
    endfunction

    logic          valid_q, valid_d;
    logic [CW-1:0] col_q, col_d;
    logic          last_q, last_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic          ready;
    logic          accept;
    logic          at_last;

    assign ready   = !valid_q || bus.out_ready;
    assign accept  = bus.in_valid && ready;
    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        valid_d = valid_q;
        col_d   = col_q;
        last_d  = last_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            col_d   = inv_mix(bus.in_col);
            last_d  = at_last;
            if (bus.in_last != at_last) begin
                err_d = 1'b1;
            end
            // A premature in_last resynchronises the counter to the next state.
            idx_d = (bus.in_last || at_last) ? '0 : idx_q + 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            col_q   <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            col_q   <= col_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_col   = col_q;
    assign bus.out_last  = last_q;
    assign bus.col_idx   = idx_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_fides_imcol_serial.sv
// Randomised and directed bench for fides_imcol_serial against a transaction-level
// model built from row parity per share and a modulo-NCOL column counter.
module tb_fides_imcol_serial;
    localparam int SH = 3;
    localparam int NC = 8;
    localparam int CW = SH * 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fides_imcol_serial_if #(.SHARES(SH), .NCOL(NC)) bus ();
    fides_imcol_serial #(.SHARES(SH), .NCOL(NC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_total = 0;
    int n_pass  = 0;

    // Model state
    logic          m_valid;
    logic [CW-1:0] m_col;
    logic          m_last;
    int            m_idx;
    logic          m_err;
    logic          m_acc;
    logic [CW-1:0] m_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Per share: row r out = XOR of the three other rows.
    function automatic logic [19:0] mix20(input logic [19:0] a);
        logic [4:0] row [4];
        logic [19:0] y;
        for (int r = 0; r < 4; r++) row[r] = a[5*r +: 5];
        y = '0;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                if (k != r) y[5*r +: 5] = y[5*r +: 5] ^ row[k];
        return y;
    endfunction

    function automatic logic [CW-1:0] mixcol(input logic [CW-1:0] c);
        logic [CW-1:0] y;
        for (int s = 0; s < SH; s++) y[20*s +: 20] = mix20(c[20*s +: 20]);
        return y;
    endfunction

    function automatic logic [19:0] share_xor(input logic [CW-1:0] c);
        logic [19:0] x = '0;
        for (int s = 0; s < SH; s++) x ^= c[20*s +: 20];
        return x;
    endfunction

    function automatic logic [CW-1:0] rand_col();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[CW-1:0];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_col = '0; m_last = 1'b0; m_idx = 0; m_err = 1'b0; m_acc = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic rdy);
        bus.in_valid  = v;
        bus.in_col    = c;
        bus.out_ready = rdy;
        bus.in_last   = (m_idx == NC - 1);
    endtask

    // One clock: check in_ready, advance model, compare registered outputs.
    task automatic tick();
        logic rdy_exp;
        #1;
        rdy_exp = !m_valid || bus.out_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(rdy_exp));
        m_acc = bus.in_valid && rdy_exp;
        m_in  = bus.in_col;
        if (m_acc) begin
            m_col   = mixcol(bus.in_col);
            m_last  = (m_idx == NC - 1);
            m_valid = 1'b1;
            if (bus.in_last != (m_idx == NC - 1)) m_err = 1'b1;
            m_idx = bus.in_last ? 0 : (m_idx + 1) % NC;
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("out_col",   64'(bus.out_col),   64'(m_col));
        chk("out_last",  64'(bus.out_last),  64'(m_last));
        chk("col_idx",   64'(bus.col_idx),   64'(m_idx));
        chk("err",       64'(bus.err),       64'(m_err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_col"},   64'(bus.out_col),   64'd0);
        chk({tag, "_last"},  64'(bus.out_last),  64'd0);
        chk({tag, "_idx"},   64'(bus.col_idx),   64'd0);
        chk({tag, "_err"},   64'(bus.err),       64'd0);
        chk({tag, "_rdy"},   64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        logic [CW-1:0] c, saved, base, mask;
        logic [CW-1:0] out_a;
        int            k, lastcnt;

        model_reset();
        drive(1'b0, '0, 1'b1);
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known vector and its involution (share 0 only)
        drive(1'b1, CW'(60'h41041), 1'b1);
        tick();
        chk("vec_fwd", 64'(bus.out_col[19:0]), 64'h3ADAE);
        chk("vec_last", 64'(bus.out_last), 64'd0);
        chk("vec_idx", 64'(bus.col_idx), 64'd1);
        drive(1'b1, CW'(60'h3ADAE), 1'b1);
        tick();
        chk("vec_inv", 64'(bus.out_col[19:0]), 64'h41041);

        // Finish the current state, then a clean 8-column back-to-back state
        while (m_idx != 0) begin drive(1'b1, rand_col(), 1'b1); tick(); end
        lastcnt = 0;
        for (int i = 0; i < NC; i++) begin
            drive(1'b1, rand_col(), 1'b1);
            tick();
            chk("b2b_valid", 64'(bus.out_valid), 64'd1);
            chk("b2b_last", 64'(bus.out_last), 64'(i == NC - 1));
            if (bus.out_last) lastcnt++;
        end
        chk("b2b_lastcnt", 64'(lastcnt), 64'd1);
        chk("b2b_wrap", 64'(bus.col_idx), 64'd0);
        chk("b2b_err", 64'(bus.err), 64'd0);

        // Share independence: flip one share of the input and compare outputs
        for (int t = 0; t < 6; t++) begin
            base = rand_col();
            k    = $urandom_range(0, SH - 1);
            mask = '0;
            mask[20*k +: 20] = 20'($urandom_range(1, 20'hFFFFF));
            drive(1'b1, base, 1'b1);
            tick();
            out_a = bus.out_col;
            chk("xor_shares", 64'(share_xor(out_a)), 64'(mix20(share_xor(base))));
            drive(1'b1, base ^ mask, 1'b1);
            tick();
            chk("share_local", 64'(out_a ^ bus.out_col), 64'(mixcol(mask)));
        end

        // Backpressure: hold out_ready low for 3 cycles with a column waiting
        drive(1'b1, rand_col(), 1'b1);
        tick();
        saved = bus.out_col;
        c = rand_col();
        drive(1'b1, c, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rdy", 64'(bus.in_ready), 64'd0);
            chk("stall_col", 64'(bus.out_col), 64'(saved));
            chk("stall_vld", 64'(bus.out_valid), 64'd1);
        end
        drive(1'b1, c, 1'b1);
        tick();
        chk("release_col", 64'(bus.out_col), 64'(mixcol(c)));

        // Randomised traffic with correct framing
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, rand_col(), $urandom_range(0, 3) != 0);
            tick();
            if (m_acc)
                chk("rnd_xor", 64'(share_xor(bus.out_col)), 64'(mix20(share_xor(m_in))));
        end
        drive(1'b0, '0, 1'b1);
        tick();
        chk("rnd_err", 64'(bus.err), 64'd0);

        // Reset mid-state at col_idx 5 with a column in flight
        while (m_idx != 5) begin drive(1'b1, rand_col(), 1'b1); tick(); end
        chk("pre_rst_vld", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, rand_col(), 1'b1);
        tick();
        chk("post_rst_idx", 64'(bus.col_idx), 64'd1);

        // Framing errors: early in_last at column 3, missing in_last at column 7
        while (m_idx != 3) begin drive(1'b1, rand_col(), 1'b1); tick(); end
        drive(1'b1, rand_col(), 1'b1);
        bus.in_last = 1'b1;
        tick();
        chk("early_err", 64'(bus.err), 64'd1);
        chk("early_idx", 64'(bus.col_idx), 64'd0);
        while (m_idx != NC - 1) begin drive(1'b1, rand_col(), 1'b1); tick(); end
        chk("err_sticky", 64'(bus.err), 64'd1);
        drive(1'b1, rand_col(), 1'b1);
        bus.in_last = 1'b0;
        tick();
        chk("late_err", 64'(bus.err), 64'd1);
        chk("late_idx", 64'(bus.col_idx), 64'd0);
        chk("late_last", 64'(bus.out_last), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
